// File: rtl/stopwatch_timer.sv
// mm:ss stopwatch core: prescaler, run/pause/lap control, minute limit, wrap pulse.
// Define STOPWATCH_HOURS_EN to add an hours digit (disp_hh, 0..23).
module stopwatch_timer #(
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int MM_MAX        = 59,
    parameter int MM_W          = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_stop,
    input  logic            lap,
    input  logic            clear,
    output logic [MM_W-1:0] disp_mm,
    output logic [5:0]      disp_ss,
`ifdef STOPWATCH_HOURS_EN
    output logic [4:0]      disp_hh,
`endif
    output logic            running,
    output logic            lap_active,
    output logic            wrap
);

    localparam int PW = $clog2(TICKS_PER_SEC);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_LAP} state_t;

    state_t          r_state, w_next;
    logic [PW-1:0]   r_presc, w_presc_n;
    logic [5:0]      r_ss, w_ss_n, r_lap_ss, w_lap_ss_n;
    logic [MM_W-1:0] r_mm, w_mm_n, r_lap_mm, w_lap_mm_n;
    logic            w_counting, w_tick, w_wrap_n, w_capture;
`ifdef STOPWATCH_HOURS_EN
    logic [4:0]      r_hh, w_hh_n, r_lap_hh, w_lap_hh_n;
`endif

    always_comb begin
        w_next = r_state;
        if (clear) begin
            w_next = S_IDLE;
        end else if (start_stop) begin
            unique case (r_state)
                S_IDLE:   w_next = S_RUN;
                S_RUN:    w_next = S_PAUSED;
                S_PAUSED: w_next = S_RUN;
                S_LAP:    w_next = S_PAUSED;
                default:  w_next = S_IDLE;
            endcase
        end else if (lap) begin
            case (r_state)
                S_RUN:   w_next = S_LAP;
                S_LAP:   w_next = S_RUN;
                default: w_next = r_state;
            endcase
        end
    end

    assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_tick     = w_counting && (r_presc == PW'(TICKS_PER_SEC - 1));
    assign w_capture  = !clear && !start_stop && lap && (r_state == S_RUN);

    // Tick is applied first; clear then overrides everything.
    always_comb begin
        w_presc_n = r_presc;
        w_ss_n    = r_ss;
        w_mm_n    = r_mm;
        w_wrap_n  = 1'b0;
`ifdef STOPWATCH_HOURS_EN
        w_hh_n    = r_hh;
`endif
        if (w_counting) begin
            w_presc_n = w_tick ? '0 : r_presc + PW'(1);
        end
        if (w_tick) begin
            if (r_ss != 6'd59) begin
                w_ss_n = r_ss + 6'd1;
            end else begin
                w_ss_n = '0;
                if (r_mm != MM_W'(MM_MAX)) begin
                    w_mm_n = r_mm + MM_W'(1);
                end else begin
                    w_mm_n = '0;
`ifdef STOPWATCH_HOURS_EN
                    if (r_hh != 5'd23) begin
                        w_hh_n = r_hh + 5'd1;
                    end else begin
                        w_hh_n   = '0;
                        w_wrap_n = 1'b1;
                    end
`else
                    w_wrap_n = 1'b1;
`endif
                end
            end
        end
        if (clear) begin
            w_presc_n = '0;
            w_ss_n    = '0;
            w_mm_n    = '0;
            w_wrap_n  = 1'b0;
`ifdef STOPWATCH_HOURS_EN
            w_hh_n    = '0;
`endif
        end
    end

    always_comb begin
        w_lap_ss_n = r_lap_ss;
        w_lap_mm_n = r_lap_mm;
`ifdef STOPWATCH_HOURS_EN
        w_lap_hh_n = r_lap_hh;
`endif
        if (clear) begin
            w_lap_ss_n = '0;
            w_lap_mm_n = '0;
`ifdef STOPWATCH_HOURS_EN
            w_lap_hh_n = '0;
`endif
        end else if (w_capture) begin
            w_lap_ss_n = w_ss_n;
            w_lap_mm_n = w_mm_n;
`ifdef STOPWATCH_HOURS_EN
            w_lap_hh_n = w_hh_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_ss       <= '0;
            r_mm       <= '0;
            r_lap_ss   <= '0;
            r_lap_mm   <= '0;
            disp_ss    <= '0;
            disp_mm    <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
            wrap       <= 1'b0;
`ifdef STOPWATCH_HOURS_EN
            r_hh       <= '0;
            r_lap_hh   <= '0;
            disp_hh    <= '0;
`endif
        end else begin
            r_state    <= w_next;
            r_presc    <= w_presc_n;
            r_ss       <= w_ss_n;
            r_mm       <= w_mm_n;
            r_lap_ss   <= w_lap_ss_n;
            r_lap_mm   <= w_lap_mm_n;
            disp_ss    <= (w_next == S_LAP) ? w_lap_ss_n : w_ss_n;
            disp_mm    <= (w_next == S_LAP) ? w_lap_mm_n : w_mm_n;
            running    <= (w_next == S_RUN) || (w_next == S_LAP);
            lap_active <= (w_next == S_LAP);
            wrap       <= w_wrap_n;
`ifdef STOPWATCH_HOURS_EN
            r_hh       <= w_hh_n;
            r_lap_hh   <= w_lap_hh_n;
            disp_hh    <= (w_next == S_LAP) ? w_lap_hh_n : w_hh_n;
`endif
        end
    end

endmodule

// File: tb/tb_stopwatch_timer.sv
// Stopwatch bench: directed scenarios plus random button traffic
// compared against an elapsed-cycle reference model.
module tb_stopwatch_timer;

    localparam int T    = 4;
    localparam int MMX  = 2;
    localparam int MW   = 3;
`ifdef STOPWATCH_HOURS_EN
    localparam int HRS  = 24;
`else
    localparam int HRS  = 1;
`endif
    localparam int HOUR = 60 * (MMX + 1);
    localparam int FULL = T * HOUR * HRS;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_LAP = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_stop = 1'b0;
    logic          lap = 1'b0;
    logic          clear = 1'b0;
    logic [MW-1:0] disp_mm;
    logic [5:0]    disp_ss;
`ifdef STOPWATCH_HOURS_EN
    logic [4:0]    disp_hh;
`endif
    logic          running, lap_active, wrap;

    stopwatch_timer #(.TICKS_PER_SEC(T), .MM_MAX(MMX), .MM_W(MW)) dut (
        .clk(clk),
        .rst(rst),
        .start_stop(start_stop),
        .lap(lap),
        .clear(clear),
        .disp_mm(disp_mm),
        .disp_ss(disp_ss),
`ifdef STOPWATCH_HOURS_EN
        .disp_hh(disp_hh),
`endif
        .running(running),
        .lap_active(lap_active),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: elapsed counted cycles modulo full scale, plus captured lap seconds.
    int m_mode  = M_IDLE;
    int m_total = 0;
    int m_lap   = 0;
    int m_wrap  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit a_rst, a_clr, a_ss, a_lap);
        if (a_rst) begin
            m_mode = M_IDLE; m_total = 0; m_lap = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            if (m_mode == M_RUN || m_mode == M_LAP) begin
                m_total = (m_total + 1) % FULL;
                if (m_total == 0) m_wrap = 1;
            end
            if (a_clr) begin
                m_mode = M_IDLE; m_total = 0; m_lap = 0; m_wrap = 0;
            end else if (a_ss) begin
                if (m_mode == M_RUN || m_mode == M_LAP) m_mode = M_PAUSED;
                else m_mode = M_RUN;
            end else if (a_lap) begin
                if (m_mode == M_RUN) begin
                    m_lap  = m_total / T;
                    m_mode = M_LAP;
                end else if (m_mode == M_LAP) begin
                    m_mode = M_RUN;
                end
            end
        end
    endtask

    task automatic check_all();
        int s;
        s = (m_mode == M_LAP) ? m_lap : m_total / T;
        chk("disp_ss", int'(disp_ss), s % 60);
        chk("disp_mm", int'(disp_mm), (s / 60) % (MMX + 1));
`ifdef STOPWATCH_HOURS_EN
        chk("disp_hh", int'(disp_hh), s / HOUR);
`endif
        chk("running", int'(running),
            int'(m_mode == M_RUN || m_mode == M_LAP));
        chk("lap_active", int'(lap_active), int'(m_mode == M_LAP));
        chk("wrap", int'(wrap), m_wrap);
    endtask

    task automatic step(input bit a_rst, a_clr, a_ss, a_lap);
        rst = a_rst; clear = a_clr; start_stop = a_ss; lap = a_lap;
        @(posedge clk);
        model_step(a_rst, a_clr, a_ss, a_lap);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        int wraps;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reset_ss", int'(disp_ss), 0);
        chk("reset_run", int'(running), 0);

        // first second after 4 cycles, second after 8
        step(0, 0, 1, 0);
        idle(4);
        chk("t1_ss_1", int'(disp_ss), 1);
        idle(4);
        chk("t1_ss_2", int'(disp_ss), 2);
        chk("t1_running", int'(running), 1);

        // pause mid-second, resume keeps the fraction
        idle(1);
        step(0, 0, 1, 0);
        idle(20);
        chk("t2_hold", int'(disp_ss), 2);
        step(0, 0, 1, 0);
        idle(1);
        chk("t2_resume1", int'(disp_ss), 2);
        idle(1);
        chk("t2_resume2", int'(disp_ss), 3);

        // lap freeze and release
        step(0, 0, 0, 1);
        idle(12);
        chk("t3_frozen", int'(disp_ss), 3);
        chk("t3_lap_act", int'(lap_active), 1);
        step(0, 0, 0, 1);
        chk("t3_live", int'(disp_ss), 6);

        // clear with simultaneous start_stop, then restart from zero prescaler
        idle(3);
        step(0, 1, 1, 0);
        chk("t5_running", int'(running), 0);
        chk("t5_ss", int'(disp_ss), 0);
        step(0, 0, 1, 0);
        idle(3);
        chk("t5_pre3", int'(disp_ss), 0);
        idle(1);
        chk("t5_tick", int'(disp_ss), 1);

        // full-scale rollover
        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        wraps = 0;
        for (int i = 0; i < FULL + 6; i++) begin
            step(0, 0, 0, 0);
            if (wrap) wraps++;
            if (i == FULL - 2) begin
                chk("t4_pre_ss", int'(disp_ss), 59);
                chk("t4_pre_mm", int'(disp_mm), MMX);
            end
            if (i == FULL - 1) begin
                chk("t4_wrap", int'(wrap), 1);
                chk("t4_zero", int'(disp_ss) + int'(disp_mm), 0);
            end
        end
        chk("t4_wrap_count", wraps, 1);

        // reset wins over lap
        step(0, 0, 0, 0);
        step(1, 0, 0, 1);
        chk("t6_lap", int'(lap_active), 0);
        chk("t6_run", int'(running), 0);
        step(0, 0, 0, 0);

        // random button traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 999) == 0,
                 $urandom_range(0, 79) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
